// File: rtl/p10_prm_access_pkg.sv
// Shared types for the parameter access path: ROM entry layout, access rights,
// response status codes, access FSM states and the parameter address map.
package p10_prm_access_pkg;

    localparam int PRM_VAL_W = 32;

    typedef enum logic [1:0] {
        RIGHTS_RW = 2'd0,
        RIGHTS_RO = 2'd1,
        RIGHTS_WO = 2'd2
    } prm_rights_t;

    typedef struct packed {
        prm_rights_t            rights;
        logic                   is_exec;
        logic [PRM_VAL_W-1:0]   min_val;
        logic [PRM_VAL_W-1:0]   max_val;
    } prm_entry_t;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_BAD_ADDR = 2'd1,
        ST_DENIED   = 2'd2,
        ST_RANGE    = 2'd3
    } prm_status_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_CHECK,
        S_RESP
    } prm_access_state_t;

    localparam int ADDR_FREQ_HZ      = 0;
    localparam int ADDR_DUTY_PERCENT = 1;
    localparam int ADDR_PHASE_DEGREE = 2;
    localparam int ADDR_APPLY        = 3;
    localparam int ADDR_FW_VERSION   = 4;
    localparam int ADDR_KEY          = 5;
    localparam int ADDR_GAIN         = 6;
    localparam int ADDR_SAVE         = 7;

endpackage

// File: rtl/p10_prm_access_if.sv
// Request/response channel between the command parser (master) and the
// parameter access controller (slave).
interface p10_prm_access_if
    import p10_prm_access_pkg::*;
#(
    parameter int AW    = 4,
    parameter int VAL_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [AW-1:0]     req_addr;
    logic [VAL_W-1:0]  req_data;
    logic              rsp_valid;
    logic              rsp_ready;
    prm_status_t       rsp_status;
    logic [VAL_W-1:0]  rsp_data;

    modport master (
        output req_valid, req_write, req_addr, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_status, rsp_data
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_status, rsp_data
    );
endinterface

// File: rtl/p10_prm_access_check.sv
// Combinational access/range checker: turns one ROM entry plus the request
// attributes into a response status. First matching rule wins.
module p10_prm_check
    import p10_prm_access_pkg::*;
#(
    parameter int VAL_W = PRM_VAL_W
) (
    input  prm_rights_t       rights,
    input  logic [VAL_W-1:0]  min_val,
    input  logic [VAL_W-1:0]  max_val,
    input  logic              write,
    input  logic [VAL_W-1:0]  data,
    input  logic              bad_addr,
    output prm_status_t       status
);
    always_comb begin
        // NOTE: default first so every path assigns status and no latch is inferred.
        status = ST_OK;
        if (bad_addr) begin
            status = ST_BAD_ADDR;
        end else if ((write && rights == RIGHTS_RO) || (!write && rights == RIGHTS_WO)) begin
            status = ST_DENIED;
        end else if (write && (data < min_val || data > max_val)) begin
            status = ST_RANGE;
        end
    end
endmodule

// File: rtl/p10_prm_access.sv
// Parameter access controller: one request at a time, fetched from the ROM,
// checked, committed to the register file or fired as an exec strobe.
module p10_prm_access
    import p10_prm_access_pkg::*;
#(
    parameter  int PRM_COUNT = 8,
    parameter  int VAL_W     = 32,
    localparam int AW        = $clog2(PRM_COUNT + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    p10_prm_access_if.slave             bus,
    output logic [AW-1:0]               rom_addr,
    input  prm_entry_t                  rom_entry,
    output logic [PRM_COUNT*VAL_W-1:0]  prm_values,
    output logic [PRM_COUNT-1:0]        exec_pulse
);
    localparam int IW = (PRM_COUNT > 1) ? $clog2(PRM_COUNT) : 1;

    prm_access_state_t state, state_nxt;

    logic                           wr_q;
    logic                           bad_addr_q;
    logic [VAL_W-1:0]               data_q;
    prm_status_t                    status;
    prm_status_t                    rsp_status_q;
    logic [VAL_W-1:0]               rsp_data_q;
    logic [PRM_COUNT-1:0][VAL_W-1:0] vals_q;
    logic                           accept;
    logic                           evaluate;
    logic                           req_bad;
    logic [IW-1:0]                  idx;

    // rom_addr is clamped into range, so it doubles as the register-file index.
    assign idx        = rom_addr[IW-1:0];
    assign req_bad    = (bus.req_addr >= AW'(PRM_COUNT));
    assign prm_values = vals_q;

    p10_prm_check #(.VAL_W(VAL_W)) u_check (
        .rights   (rom_entry.rights),
        .min_val  (rom_entry.min_val),
        .max_val  (rom_entry.max_val),
        .write    (wr_q),
        .data     (data_q),
        .bad_addr (bad_addr_q),
        .status   (status)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.req_valid) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_CHECK;
            S_CHECK: state_nxt = S_RESP;
            S_RESP:  if (bus.rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state == S_IDLE);
        bus.rsp_valid  = (state == S_RESP);
        bus.rsp_status = rsp_status_q;
        bus.rsp_data   = rsp_data_q;
        accept         = (state == S_IDLE) && bus.req_valid;
        evaluate       = (state == S_CHECK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q         <= 1'b0;
            bad_addr_q   <= 1'b0;
            data_q       <= '0;
            rom_addr     <= '0;
            rsp_status_q <= ST_OK;
            rsp_data_q   <= '0;
            // NOTE: the register file is reset because stored values are architecturally visible as 0.
            vals_q       <= '0;
            exec_pulse   <= '0;
        end else begin
            exec_pulse <= '0;
            if (accept) begin
                wr_q       <= bus.req_write;
                data_q     <= bus.req_data;
                bad_addr_q <= req_bad;
                rom_addr   <= req_bad ? '0 : bus.req_addr;
            end
            // The outcome is decided once in CHECK, so a stalled RESP cannot repeat a strobe.
            if (evaluate) begin
                rsp_status_q <= status;
                rsp_data_q   <= '0;
                if (status == ST_OK) begin
                    if (wr_q) begin
                        if (!rom_entry.is_exec)  vals_q[idx]     <= data_q;
                        else if (data_q != '0)   exec_pulse[idx] <= 1'b1;
                    end else if (!rom_entry.is_exec) begin
                        rsp_data_q <= vals_q[idx];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_p10_prm_access.sv
// Bench for p10_prm_access: ROM model, directed vector table, hand-written
// corner sequences and randomized traffic against an array-based reference.
module tb_p10_prm_access;
    import p10_prm_access_pkg::*;

    localparam int PRM_COUNT = 8;
    localparam int VAL_W     = 32;
    localparam int AW        = $clog2(PRM_COUNT + 1);
    localparam int FW        = PRM_COUNT * VAL_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    p10_prm_access_if #(.AW(AW), .VAL_W(VAL_W)) bus ();

    logic [AW-1:0]          rom_addr;
    prm_entry_t             rom_entry;
    logic [FW-1:0]          prm_values;
    logic [PRM_COUNT-1:0]   exec_pulse;

    p10_prm_access #(.PRM_COUNT(PRM_COUNT), .VAL_W(VAL_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .rom_addr   (rom_addr),
        .rom_entry  (rom_entry),
        .prm_values (prm_values),
        .exec_pulse (exec_pulse)
    );

    // ROM with one registered read cycle; contents may be patched by the test.
    prm_entry_t rom_tbl [PRM_COUNT];
    always @(posedge clk) begin
        if (rom_addr < AW'(PRM_COUNT)) rom_entry <= rom_tbl[rom_addr[AW-2:0]];
        else                           rom_entry <= '0;
    end

    int n_checks = 0;
    int n_errors = 0;
    logic [VAL_W-1:0] model_vals [PRM_COUNT];

    typedef struct {
        logic        wr;
        int          addr;
        logic [31:0] data;
        int          hold;
        prm_status_t exp_st;
        logic [31:0] exp_rd;
        logic [7:0]  exp_pulse;
    } vec_t;

    typedef struct {
        prm_status_t            st;
        logic [VAL_W-1:0]       rd;
        int                     lat;
        logic [AW-1:0]          ra1;
        int                     pulse_n;
        logic [PRM_COUNT-1:0]   pulse_at;
        logic [FW-1:0]          vals;
        bit                     unstable;
        bit                     ready_after;
        bit                     timeout;
    } res_t;

    vec_t vecs [24];

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    function automatic logic [FW-1:0] model_flat();
        logic [FW-1:0] f;
        for (int i = 0; i < PRM_COUNT; i++) f[i*VAL_W +: VAL_W] = model_vals[i];
        return f;
    endfunction

    // Reference: applies the access rules directly to the ROM table and value array.
    function automatic void model_eval(input logic wr, input int addr, input logic [31:0] d,
                                       output prm_status_t st, output logic [31:0] rd,
                                       output logic [7:0] pulse);
        prm_entry_t e;
        st = ST_OK; rd = '0; pulse = '0;
        if (addr >= PRM_COUNT) begin
            st = ST_BAD_ADDR;
        end else begin
            e = rom_tbl[addr];
            if (wr ? (e.rights == RIGHTS_RO) : (e.rights == RIGHTS_WO)) st = ST_DENIED;
            else if (wr && (d < e.min_val || d > e.max_val))             st = ST_RANGE;
            else if (wr && e.is_exec)  begin if (d != 0) pulse[addr] = 1'b1; end
            else if (wr)               model_vals[addr] = d;
            else                       rd = e.is_exec ? '0 : model_vals[addr];
        end
    endfunction

    // Runs one request; entered and left at a falling edge. req_valid stays high
    // and req_* are scrambled while in flight, which the DUT must ignore.
    task automatic run_txn(input logic wr, input int addr, input logic [31:0] data,
                           input int hold, output res_t r);
        int  cyc;
        bit  got, done;
        r.st = ST_OK; r.rd = '0; r.lat = 0; r.ra1 = '0; r.pulse_n = 0; r.pulse_at = '0;
        r.vals = '0; r.unstable = 0; r.ready_after = 0; r.timeout = 0;
        cyc = 0;
        while (!bus.req_ready && cyc < 50) begin @(negedge clk); cyc++; end
        if (!bus.req_ready) begin r.timeout = 1; return; end
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = AW'(addr);
        bus.req_data  = data;
        bus.rsp_ready = (hold == 0);
        @(posedge clk);
        cyc = 0; got = 0; done = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                r.ra1 = rom_addr;
                bus.req_write = ~wr;
                bus.req_addr  = AW'(addr + 1);
                bus.req_data  = ~data;
            end
            if (exec_pulse != '0) r.pulse_n++;
            if (bus.rsp_valid && !got) begin
                got = 1; r.lat = cyc; r.st = bus.rsp_status; r.rd = bus.rsp_data;
                r.pulse_at = exec_pulse; r.vals = prm_values;
            end else if (got) begin
                if (!bus.rsp_valid || bus.rsp_status !== r.st || bus.rsp_data !== r.rd || bus.req_ready)
                    r.unstable = 1;
            end
            if (got && cyc >= r.lat + hold) begin
                bus.rsp_ready = 1'b1;
                @(posedge clk);
                @(negedge clk);
                r.ready_after = bus.req_ready;
                if (exec_pulse != '0) r.pulse_n++;
                done = 1;
            end
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        if (!done) r.timeout = 1;
    endtask

    task automatic check_result(input string tag, input int addr, input int hold,
                                input prm_status_t exp_st, input logic [31:0] exp_rd,
                                input logic [7:0] exp_pulse, input res_t r);
        if (r.timeout) begin fail_bound({tag, "_timeout"}); return; end
        check({tag, "_latency"}, r.lat, 3);
        check({tag, "_status"}, r.st, exp_st);
        check({tag, "_rsp_data"}, r.rd, exp_rd);
        check({tag, "_rom_addr"}, r.ra1, (addr < PRM_COUNT) ? AW'(addr) : '0);
        check({tag, "_pulse_at_resp"}, r.pulse_at, exp_pulse);
        check({tag, "_pulse_count"}, r.pulse_n, (exp_pulse != 0) ? 1 : 0);
        check({tag, "_prm_values"}, r.vals, model_flat());
        check({tag, "_ready_after"}, r.ready_after, 1);
        if (hold > 0) check({tag, "_rsp_stable"}, r.unstable, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t          r;
        prm_status_t   m_st;
        logic [31:0]   m_rd;
        logic [7:0]    m_pl;
        logic [31:0]   d;
        int            a, sel;
        logic          w;
        bit            seen;

        rom_tbl[ADDR_FREQ_HZ]      = '{RIGHTS_RW, 1'b0, 32'd1,  32'd1000000};
        rom_tbl[ADDR_DUTY_PERCENT] = '{RIGHTS_RW, 1'b0, 32'd0,  32'd50};
        rom_tbl[ADDR_PHASE_DEGREE] = '{RIGHTS_RW, 1'b0, 32'd0,  32'd359};
        rom_tbl[ADDR_APPLY]        = '{RIGHTS_RW, 1'b1, 32'd0,  32'd1};
        rom_tbl[ADDR_FW_VERSION]   = '{RIGHTS_RO, 1'b0, 32'd0,  32'hFFFF_FFFF};
        rom_tbl[ADDR_KEY]          = '{RIGHTS_WO, 1'b0, 32'd0,  32'hFFFF_FFFF};
        rom_tbl[ADDR_GAIN]         = '{RIGHTS_RW, 1'b0, 32'd10, 32'd1000};
        rom_tbl[ADDR_SAVE]         = '{RIGHTS_RW, 1'b1, 32'd0,  32'd255};
        for (int i = 0; i < PRM_COUNT; i++) model_vals[i] = '0;

        vecs[0]  = '{1'b1, ADDR_FREQ_HZ,      32'd500000,  0,  ST_OK,       32'd0,       8'h00};
        vecs[1]  = '{1'b0, ADDR_FREQ_HZ,      32'd0,       0,  ST_OK,       32'd500000,  8'h00};
        vecs[2]  = '{1'b1, ADDR_DUTY_PERCENT, 32'd51,      0,  ST_RANGE,    32'd0,       8'h00};
        vecs[3]  = '{1'b0, ADDR_DUTY_PERCENT, 32'd0,       0,  ST_OK,       32'd0,       8'h00};
        vecs[4]  = '{1'b1, ADDR_DUTY_PERCENT, 32'd50,      0,  ST_OK,       32'd0,       8'h00};
        vecs[5]  = '{1'b0, ADDR_DUTY_PERCENT, 32'd0,       1,  ST_OK,       32'd50,      8'h00};
        vecs[6]  = '{1'b1, ADDR_PHASE_DEGREE, 32'd360,     0,  ST_RANGE,    32'd0,       8'h00};
        vecs[7]  = '{1'b1, ADDR_PHASE_DEGREE, 32'd359,     0,  ST_OK,       32'd0,       8'h00};
        vecs[8]  = '{1'b1, ADDR_APPLY,        32'd1,       0,  ST_OK,       32'd0,       8'h08};
        vecs[9]  = '{1'b1, ADDR_APPLY,        32'd0,       0,  ST_OK,       32'd0,       8'h00};
        vecs[10] = '{1'b0, ADDR_APPLY,        32'd0,       0,  ST_OK,       32'd0,       8'h00};
        vecs[11] = '{1'b1, ADDR_APPLY,        32'd2,       0,  ST_RANGE,    32'd0,       8'h00};
        vecs[12] = '{1'b1, 8,                 32'd5,       0,  ST_BAD_ADDR, 32'd0,       8'h00};
        vecs[13] = '{1'b0, 15,                32'd0,       0,  ST_BAD_ADDR, 32'd0,       8'h00};
        vecs[14] = '{1'b1, ADDR_FW_VERSION,   32'd7,       0,  ST_DENIED,   32'd0,       8'h00};
        vecs[15] = '{1'b0, ADDR_FW_VERSION,   32'd0,       0,  ST_OK,       32'd0,       8'h00};
        vecs[16] = '{1'b0, ADDR_KEY,          32'd0,       0,  ST_DENIED,   32'd0,       8'h00};
        vecs[17] = '{1'b1, ADDR_KEY,          32'h1234,    0,  ST_OK,       32'd0,       8'h00};
        vecs[18] = '{1'b1, ADDR_FREQ_HZ,      32'd0,       0,  ST_RANGE,    32'd0,       8'h00};
        vecs[19] = '{1'b1, ADDR_FREQ_HZ,      32'd1000000, 0,  ST_OK,       32'd0,       8'h00};
        vecs[20] = '{1'b0, ADDR_FREQ_HZ,      32'd0,       0,  ST_OK,       32'd1000000, 8'h00};
        vecs[21] = '{1'b1, ADDR_APPLY,        32'd1,       10, ST_OK,       32'd0,       8'h08};
        vecs[22] = '{1'b0, ADDR_SAVE,         32'd0,       0,  ST_OK,       32'd0,       8'h00};
        vecs[23] = '{1'b1, ADDR_SAVE,         32'd200,     2,  ST_OK,       32'd0,       8'h80};

        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_data = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_req_ready",  bus.req_ready,  1);
        check("reset_rsp_valid",  bus.rsp_valid,  0);
        check("reset_rsp_status", bus.rsp_status, ST_OK);
        check("reset_rsp_data",   bus.rsp_data,   0);
        check("reset_rom_addr",   rom_addr,       0);
        check("reset_prm_values", prm_values,     0);
        check("reset_exec_pulse", exec_pulse,     0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            run_txn(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].hold, r);
            model_eval(vecs[i].wr, vecs[i].addr, vecs[i].data, m_st, m_rd, m_pl);
            check_result($sformatf("vec%0d", i), vecs[i].addr, vecs[i].hold,
                         vecs[i].exp_st, vecs[i].exp_rd, vecs[i].exp_pulse, r);
        end

        // A writable entry patched to read-only must deny writes.
        rom_tbl[ADDR_DUTY_PERCENT].rights = RIGHTS_RO;
        run_txn(1'b1, ADDR_DUTY_PERCENT, 32'd20, 0, r);
        model_eval(1'b1, ADDR_DUTY_PERCENT, 32'd20, m_st, m_rd, m_pl);
        check_result("patched_ro", ADDR_DUTY_PERCENT, 0, ST_DENIED, 32'd0, 8'h00, r);
        rom_tbl[ADDR_DUTY_PERCENT].rights = RIGHTS_RW;

        for (int i = 0; i < 60; i++) begin
            w   = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 9) == 9) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
            sel = $urandom_range(0, 5);
            d   = $urandom;
            if (a < PRM_COUNT) begin
                case (sel)
                    0: d = rom_tbl[a].min_val;
                    1: d = rom_tbl[a].max_val;
                    2: d = rom_tbl[a].min_val - 32'd1;
                    3: d = rom_tbl[a].max_val + 32'd1;
                    4: d = 32'd0;
                    default: d = $urandom_range(0, 2000);
                endcase
            end
            sel = $urandom_range(0, 3);
            run_txn(w, a, d, sel, r);
            model_eval(w, a, d, m_st, m_rd, m_pl);
            check_result($sformatf("rnd%0d", i), a, sel, m_st, m_rd, m_pl, r);
        end

        // Reset arriving during CHECK of a write drops the commit and the response.
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = AW'(ADDR_FREQ_HZ);
        bus.req_data = 32'd1000; bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_req_ready",  bus.req_ready,  1);
        check("midrst_rsp_valid",  bus.rsp_valid,  0);
        check("midrst_rsp_status", bus.rsp_status, ST_OK);
        check("midrst_rsp_data",   bus.rsp_data,   0);
        check("midrst_rom_addr",   rom_addr,       0);
        check("midrst_prm_values", prm_values,     0);
        check("midrst_exec_pulse", exec_pulse,     0);
        @(negedge clk);
        rst = 1'b0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < PRM_COUNT; i++) model_vals[i] = '0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.rsp_valid || prm_values != '0 || exec_pulse != '0) seen = 1;
        end
        check("midrst_no_activity", seen, 0);
        run_txn(1'b0, ADDR_FREQ_HZ, 32'd0, 0, r);
        model_eval(1'b0, ADDR_FREQ_HZ, 32'd0, m_st, m_rd, m_pl);
        check_result("post_rst_read", ADDR_FREQ_HZ, 0, ST_OK, 32'd0, 8'h00, r);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
